// File: rtl/sync_filter_multi_pkg.sv
// rtl/sync_filter_multi_pkg.sv - shared constants and helpers for the input synchronizer
package sync_pkg;

  localparam logic SYNC_RST_DEFAULT = 1'b0;

  // A filter of length 1 or 2 still needs one counter bit to stay legal.
  function automatic int cnt_width(input int filter_len);
    return (filter_len <= 2) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/sync_filter_multi_if.sv
// rtl/sync_filter_multi_if.sv - level inputs and filtered level/edge outputs of the synchronizer
interface sync_filter_multi_if #(
  parameter int NUM_CH = 1
) ();

  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic              any_change;

  modport master (
    output async_in,
    input  sync_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_change
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise_pulse,
    output fall_pulse,
    output any_change
  );

endinterface

// File: rtl/sync_filter_multi_chan.sv
// rtl/sync_filter_multi_chan.sv - one channel: flop chain, stability filter, output and edge flops
module sync_chan
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 1,
  parameter logic RST_VAL    = SYNC_RST_DEFAULT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int             CW      = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_chan: STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("sync_chan: FILTER_LEN must be at least 1");
  end

  logic [STAGES-1:0] chain;
  logic              cand;
  logic [CW-1:0]     cnt;

  // Only chain[0] samples the raw input; nothing else may look at the early stages.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign cand = chain[STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= '0;
      sync_out   <= RST_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else if (cand == sync_out) begin
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt        <= '0;
      sync_out   <= cand;
      rise_pulse <= cand;
      fall_pulse <= ~cand;
    end else begin
      cnt        <= cnt + 1'b1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_filter_multi.sv
// rtl/sync_filter_multi.sv - multi-channel synchronizer with glitch filter and edge strobes
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int   NUM_CH     = 1,
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 1,
  parameter logic RST_VAL    = SYNC_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sync_filter_multi_if.slave    bus
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("sync_filter_multi: NUM_CH must be at least 1");
  end

  logic [NUM_CH-1:0] sync_vec;
  logic [NUM_CH-1:0] rise_vec;
  logic [NUM_CH-1:0] fall_vec;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    sync_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RST_VAL    (RST_VAL)
    ) u_chan (
      .clk        (clk),
      .n_rst      (n_rst),
      .async_in   (bus.async_in[g]),
      .sync_out   (sync_vec[g]),
      .rise_pulse (rise_vec[g]),
      .fall_pulse (fall_vec[g])
    );
  end

  assign bus.sync_out   = sync_vec;
  assign bus.rise_pulse = rise_vec;
  assign bus.fall_pulse = fall_vec;
  // Built straight from the pulse flops so it adds no cycle of latency.
  assign bus.any_change = |{rise_vec, fall_vec};

endmodule

// File: tb/tb_sync_filter_multi.sv
// tb/tb_sync_filter_multi.sv - randomized and directed bench for sync_filter_multi against a window model
module tb_sync_filter_multi;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [7:0] in_a;
  logic [3:0] in_b;
  logic       in_c;

  sync_filter_multi_if #(.NUM_CH(8)) bus_a ();
  sync_filter_multi_if #(.NUM_CH(4)) bus_b ();
  sync_filter_multi_if #(.NUM_CH(1)) bus_c ();

  assign bus_a.async_in = in_a;
  assign bus_b.async_in = in_b;
  assign bus_c.async_in = in_c;

  sync_filter_multi #(.NUM_CH(8), .STAGES(3), .FILTER_LEN(4), .RST_VAL(1'b0)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a.slave));
  sync_filter_multi #(.NUM_CH(4), .STAGES(2), .FILTER_LEN(2), .RST_VAL(1'b1)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b.slave));
  sync_filter_multi dut_c (
    .clk(clk), .n_rst(n_rst), .bus(bus_c.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int rise1 = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: input history per instance; the output flips once the candidate
  // (input delayed by STAGES) has disagreed with it for FILTER_LEN straight edges.
  int         stg [3] = '{3, 2, 2};
  int         fln [3] = '{4, 2, 1};
  logic       rv  [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] nm  [3] = '{8'hFF, 8'h0F, 8'h01};
  logic [7:0] hist [3][32];
  logic [7:0] mo [3];
  logic [7:0] mr [3];
  logic [7:0] mf [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 32; j++) hist[k][j] = {8{rv[k]}};
      mo[k] = {8{rv[k]}};
      mr[k] = 8'h00;
      mf[k] = 8'h00;
    end
  endtask

  task automatic model_edge(input int k, input logic [7:0] v);
    logic [7:0] nxt;
    logic       diff;
    nxt = mo[k];
    for (int i = 0; i < 8; i++) begin
      diff = 1'b1;
      for (int j = 0; j < fln[k]; j++)
        if (hist[k][stg[k] - 1 + j][i] == mo[k][i]) diff = 1'b0;
      if (diff) nxt[i] = ~mo[k][i];
    end
    mr[k] = nxt & ~mo[k] & nm[k];
    mf[k] = ~nxt & mo[k] & nm[k];
    mo[k] = nxt;
    for (int j = 31; j > 0; j--) hist[k][j] = hist[k][j-1];
    hist[k][0] = v;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, in_a);
    model_edge(1, {4'h0, in_b});
    model_edge(2, {7'h0, in_c});
    #1;
    chk("a_sync", bus_a.sync_out, mo[0] & nm[0]);
    chk("a_rise", bus_a.rise_pulse, mr[0]);
    chk("a_fall", bus_a.fall_pulse, mf[0]);
    chk("a_any", {7'h0, bus_a.any_change}, {7'h0, |(mr[0] | mf[0])});
    chk("b_sync", {4'h0, bus_b.sync_out}, mo[1] & nm[1]);
    chk("b_rise", {4'h0, bus_b.rise_pulse}, mr[1]);
    chk("b_fall", {4'h0, bus_b.fall_pulse}, mf[1]);
    chk("b_any", {7'h0, bus_b.any_change}, {7'h0, |(mr[1] | mf[1])});
    chk("c_sync", {7'h0, bus_c.sync_out}, mo[2] & nm[2]);
    chk("c_delay", {7'h0, bus_c.sync_out}, {7'h0, hist[2][2][0]});
    chk("c_rise", {7'h0, bus_c.rise_pulse}, mr[2]);
    chk("c_fall", {7'h0, bus_c.fall_pulse}, mf[2]);
    rise1 += int'(bus_a.rise_pulse[1]);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    in_a  = 8'h00;
    in_b  = 4'hF;
    in_c  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_sync", bus_a.sync_out, 8'h00);
    chk("rst_b_sync", {4'h0, bus_b.sync_out}, 8'h0F);
    chk("rst_b_pulse", {bus_b.rise_pulse, bus_b.fall_pulse}, 8'h00);
    chk("rst_any", {5'h0, bus_a.any_change, bus_b.any_change, bus_c.any_change}, 8'h00);
    @(negedge clk);
    n_rst = 1'b1;

    // Latency: change before edge 1 shows up at edge STAGES+FILTER_LEN = 7.
    in_a = 8'h01;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) chk("lat_e6_sync", {7'h0, bus_a.sync_out[0]}, 8'h00);
      if (e == 7) begin
        chk("lat_e7_sync", {7'h0, bus_a.sync_out[0]}, 8'h01);
        chk("lat_e7_rise", {7'h0, bus_a.rise_pulse[0]}, 8'h01);
      end
      if (e == 8) chk("lat_e8_rise", {7'h0, bus_a.rise_pulse[0]}, 8'h00);
    end

    // Glitch of 3 cycles is dropped; 4 cycles is accepted once.
    rise1 = 0;
    in_a[1] = 1'b1;
    repeat (3) step();
    in_a[1] = 1'b0;
    repeat (10) step();
    chk("glitch_sync", {7'h0, bus_a.sync_out[1]}, 8'h00);
    chk("glitch_pulses", 8'(rise1), 8'd0);
    in_a[1] = 1'b1;
    repeat (4) step();
    in_a[1] = 1'b0;
    repeat (10) step();
    chk("hold_pulses", 8'(rise1), 8'd1);

    // Simultaneous rises on bits 0, 3 and 7.
    in_a = 8'h00;
    repeat (12) step();
    in_a = 8'h89;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) chk("multi_e6_any", {7'h0, bus_a.any_change}, 8'h00);
      if (e == 7) begin
        chk("multi_e7_rise", bus_a.rise_pulse, 8'h89);
        chk("multi_e7_any", {7'h0, bus_a.any_change}, 8'h01);
      end
      if (e == 8) begin
        chk("multi_e8_rise", bus_a.rise_pulse, 8'h00);
        chk("multi_e8_any", {7'h0, bus_a.any_change}, 8'h00);
      end
    end

    // Fall path on bit 2.
    in_a = 8'h8D;
    repeat (12) step();
    in_a = 8'h89;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) chk("fall_e6", bus_a.fall_pulse, 8'h00);
      if (e == 7) begin
        chk("fall_e7", bus_a.fall_pulse, 8'h04);
        chk("fall_e7_rise", bus_a.rise_pulse, 8'h00);
      end
      if (e == 8) chk("fall_e8", bus_a.fall_pulse, 8'h00);
    end

    // Random traffic with one asynchronous reset landing mid-count.
    for (int n = 0; n < 600; n++) begin
      in_a = in_a ^ 8'($urandom & $urandom & $urandom);
      in_b = in_b ^ 4'($urandom & $urandom);
      if (n % 2 == 0) in_c = 1'($urandom);
      if (n == 300) begin
        in_b = ~mo[1][3:0];
        repeat (3) step();
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_b_sync", {4'h0, bus_b.sync_out}, 8'h0F);
        chk("midrst_b_pulse", {bus_b.rise_pulse, bus_b.fall_pulse}, 8'h00);
        chk("midrst_a_sync", bus_a.sync_out, 8'h00);
        chk("midrst_any", {5'h0, bus_a.any_change, bus_b.any_change, bus_c.any_change}, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
